// File: rtl/seg_scan_display.sv
// Six-digit multiplexed 7-segment driver for the time-of-day clock.
// Scans one digit per dwell, blinks the pair under adjustment, shows separators.
module seg_scan_display #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLINK_DIV = 12500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] cur_h_ten,
  input  logic [3:0] cur_h_one,
  input  logic [3:0] cur_m_ten,
  input  logic [3:0] cur_m_one,
  input  logic [3:0] cur_s_ten,
  input  logic [3:0] cur_s_one,
  input  logic [1:0] adjust_mode,
  output logic [7:0] seg,
  output logic [5:0] an
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(BLINK_DIV);
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  logic [SW-1:0]      scan_cnt_q, scan_cnt_d;
  logic [BW-1:0]      blink_cnt_q, blink_cnt_d;
  logic               phase_q, phase_d;
  logic               run_q, run_d;
  logic [2:0]         idx_q, idx_d;
  logic [1:0]         mode_q;
  logic [5:0][3:0]    shadow_q, shadow_d;
  logic [5:0]         an_q, an_d;
  logic [7:0]         seg_q, seg_d;

  logic               scan_tick;
  logic               wrap;
  logic               mode_chg;
  logic               phase_eff;
  logic               blank;
  logic               dp;
  logic [3:0]         digit;
  logic [5:0][3:0]    live;

  function automatic logic [6:0] dec(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'd0:    p = 7'h3F;
      4'd1:    p = 7'h06;
      4'd2:    p = 7'h5B;
      4'd3:    p = 7'h4F;
      4'd4:    p = 7'h66;
      4'd5:    p = 7'h6D;
      4'd6:    p = 7'h7D;
      4'd7:    p = 7'h07;
      4'd8:    p = 7'h7F;
      4'd9:    p = 7'h6F;
      default: p = 7'h40;
    endcase
    return p;
  endfunction

  assign live = {cur_h_ten, cur_h_one, cur_m_ten,
                 cur_m_one, cur_s_ten, cur_s_one};

  always_comb begin
    scan_tick   = (scan_cnt_q == SCAN_LAST);
    scan_cnt_d  = scan_tick ? '0 : scan_cnt_q + 1'b1;
    run_d       = run_q | scan_tick;
    // first tick after reset also starts a frame at index 0
    wrap        = scan_tick && (!run_q || idx_q == 3'd5);
    idx_d       = idx_q;
    if (scan_tick) idx_d = wrap ? 3'd0 : idx_q + 3'd1;
    shadow_d    = wrap ? live : shadow_q;

    mode_chg    = (adjust_mode != mode_q);
    blink_cnt_d = blink_cnt_q + 1'b1;
    phase_d     = phase_q;
    if (mode_chg) begin
      blink_cnt_d = '0;
      phase_d     = 1'b0;
    end else if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end
    phase_eff   = phase_q & ~mode_chg;

    digit = 4'd0;
    case (idx_d)
      3'd0:    digit = shadow_d[0];
      3'd1:    digit = shadow_d[1];
      3'd2:    digit = shadow_d[2];
      3'd3:    digit = shadow_d[3];
      3'd4:    digit = shadow_d[4];
      3'd5:    digit = shadow_d[5];
      default: digit = 4'd0;
    endcase
    blank = phase_eff && (adjust_mode == idx_d[2:1] + 2'd1);
    dp    = (adjust_mode == 2'd0) && (idx_d == 3'd2 || idx_d == 3'd4);

    an_d  = an_q;
    seg_d = seg_q;
    if (scan_tick) begin
      an_d  = 6'b1 << idx_d;
      seg_d = blank ? 8'h00 : {dp, dec(digit)};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt_q  <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      run_q       <= 1'b0;
      idx_q       <= 3'd0;
      mode_q      <= 2'd0;
      shadow_q    <= '0;
      an_q        <= '0;
      seg_q       <= '0;
    end else begin
      scan_cnt_q  <= scan_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      run_q       <= run_d;
      idx_q       <= idx_d;
      mode_q      <= adjust_mode;
      shadow_q    <= shadow_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// Bench for seg_scan_display: time-indexed reference model feeding a
// scoreboard, plus per-scenario directed checks.
module tb_seg_scan_display;

  localparam int SCAN  = 4;
  localparam int BLINK = 16;

  logic       clk;
  logic       rst_n;
  logic [3:0] h_ten, h_one, m_ten, m_one, s_ten, s_one;
  logic [1:0] mode;
  logic [7:0] seg;
  logic [5:0] an;

  int checks = 0;
  int errors = 0;

  seg_scan_display #(.SCAN_DIV(SCAN), .BLINK_DIV(BLINK)) dut (
    .clk(clk), .rst_n(rst_n),
    .cur_h_ten(h_ten), .cur_h_one(h_one),
    .cur_m_ten(m_ten), .cur_m_one(m_one),
    .cur_s_ten(s_ten), .cur_s_one(s_one),
    .adjust_mode(mode), .seg(seg), .an(an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0] an;
    logic [7:0] seg;
  } exp_t;

  exp_t sb[$];

  function automatic logic [6:0] pat(input logic [3:0] d);
    logic [6:0] t [16];
    t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
          7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
    return t[d];
  endfunction

  // Model: counts edges since reset release and since the last mode change.
  int         m_c;
  int         m_e;
  logic [1:0] m_mode;
  logic [3:0] m_sh [6];
  exp_t       m_out;

  initial begin
    int  idx;
    bit  chg, ph, blank, dp;
    m_c = 0; m_e = 0; m_mode = 0; m_out = '0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_c = 0; m_e = 0; m_mode = 0; m_out = '0;
        for (int i = 0; i < 6; i++) m_sh[i] = 4'd0;
        sb.delete();
        sb.push_back(exp_t'(0));
      end else begin
        chg = (mode != m_mode);
        ph  = chg ? 1'b0 : (((m_e / BLINK) % 2) == 1);
        m_c++;
        if (m_c % SCAN == 0) begin
          idx = (m_c / SCAN - 1) % 6;
          if (idx == 0) begin
            m_sh[0] = s_one; m_sh[1] = s_ten; m_sh[2] = m_one;
            m_sh[3] = m_ten; m_sh[4] = h_one; m_sh[5] = h_ten;
          end
          blank = ph && mode != 0 && (idx / 2) == (int'(mode) - 1);
          dp    = mode == 0 && (idx == 2 || idx == 4);
          m_out.an  = 6'(1 << idx);
          m_out.seg = blank ? 8'h00 : {dp, pat(m_sh[idx])};
        end
        m_e    = chg ? 0 : m_e + 1;
        m_mode = mode;
        sb.push_back(m_out);
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (an !== e.an || seg !== e.seg) begin
          errors++;
          $display("FAIL sb t=%0t an=%b exp=%b seg=%h exp=%h",
                   $time, an, e.an, seg, e.seg);
        end
      end
    end
  end

  task automatic test_reset();
    logic [7:0] tbl [6];
    tbl = '{8'h7D, 8'h6D, 8'hE6, 8'h4F, 8'hDB, 8'h06};
    rst_n = 1'b0;
    {h_ten, h_one, m_ten, m_one, s_ten, s_one} = {4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
    mode = 2'd0;
    repeat (3) @(negedge clk);
    checks++;
    if (an !== 6'b0 || seg !== 8'h00) begin
      errors++;
      $display("FAIL in_reset an=%b seg=%h exp 000000/00", an, seg);
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (an !== 6'b0) begin
        errors++;
        $display("FAIL dark an=%b exp=000000", an);
      end
    end
    @(negedge clk);
    checks++;
    if (an !== 6'b000001 || seg !== tbl[0]) begin
      errors++;
      $display("FAIL first_digit an=%b seg=%h exp 000001/%h", an, seg, tbl[0]);
    end
    for (int i = 1; i < 7; i++) begin
      repeat (SCAN) @(negedge clk);
      checks++;
      if (an !== 6'(1 << (i % 6)) || seg !== tbl[i % 6]) begin
        errors++;
        $display("FAIL scan%0d an=%b seg=%h exp=%h", i, an, seg, tbl[i % 6]);
      end
    end
  endtask

  task automatic test_snapshot();
    repeat (2 * SCAN) @(negedge clk);
    m_ten = 4'd9;
    s_one = 4'd7;
    repeat (SCAN) @(negedge clk);
    checks++;
    if (an !== 6'b001000 || seg !== 8'h4F) begin
      errors++;
      $display("FAIL snap_old an=%b seg=%h exp 001000/4f", an, seg);
    end
    repeat (3 * SCAN) @(negedge clk);
    checks++;
    if (an !== 6'b000001 || seg !== 8'h07) begin
      errors++;
      $display("FAIL snap_new an=%b seg=%h exp 000001/07", an, seg);
    end
    repeat (3 * SCAN) @(negedge clk);
    checks++;
    if (an !== 6'b001000 || seg !== 8'h6F) begin
      errors++;
      $display("FAIL snap_m_ten an=%b seg=%h exp 001000/6f", an, seg);
    end
  endtask

  task automatic test_blink();
    int lit = 0;
    int dark = 0;
    mode = 2'd2;
    repeat (96) begin
      @(negedge clk);
      if ((an & 6'b110011) != 0) begin
        checks++;
        if (seg === 8'h00 || seg[7] !== 1'b0) begin
          errors++;
          $display("FAIL blink_other an=%b seg=%h", an, seg);
        end
      end
      if ((an & 6'b001100) != 0) begin
        if (seg == 8'h00) dark++;
        else lit++;
      end
    end
    checks++;
    if (lit == 0 || dark == 0) begin
      errors++;
      $display("FAIL blink_pair lit=%0d dark=%0d exp both >0", lit, dark);
    end
  endtask

  task automatic test_mode_restart();
    int n = 0;
    while (((m_e / BLINK) % 2) != 1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 64) begin
      errors++;
      $display("FAIL restart_sync waited=%0d exp <64", n);
    end
    mode = 2'd3;
    for (int i = 1; i <= BLINK; i++) begin
      @(negedge clk);
      if ((an & 6'b110000) != 0 || (i > SCAN && (an & 6'b001100) != 0)) begin
        checks++;
        if (seg === 8'h00 || seg[7] !== 1'b0) begin
          errors++;
          $display("FAIL restart_lit i=%0d an=%b seg=%h", i, an, seg);
        end
      end
    end
    repeat (48) @(negedge clk);
  endtask

  task automatic test_invalid();
    int hits = 0;
    mode  = 2'd0;
    h_ten = 4'd12;
    repeat (7 * SCAN) @(negedge clk);
    repeat (6 * SCAN) begin
      @(negedge clk);
      if (an == 6'b100000) begin
        hits++;
        checks++;
        if (seg !== 8'h40) begin
          errors++;
          $display("FAIL invalid_bcd seg=%h exp=40", seg);
        end
      end
    end
    checks++;
    if (hits == 0) begin
      errors++;
      $display("FAIL invalid_seen hits=%0d exp >0", hits);
    end
  endtask

  task automatic test_mid_reset();
    int n = 0;
    while (an !== 6'b001000 && n < 30) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 30) begin
      errors++;
      $display("FAIL midrst_sync waited=%0d exp <30", n);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (an !== 6'b0 || seg !== 8'h00) begin
      errors++;
      $display("FAIL async_rst an=%b seg=%h exp 000000/00", an, seg);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (an !== 6'b0) begin
        errors++;
        $display("FAIL rst_dark an=%b exp=000000", an);
      end
    end
    @(negedge clk);
    checks++;
    if (an !== 6'b000001 || seg !== 8'h07) begin
      errors++;
      $display("FAIL rst_restart an=%b seg=%h exp 000001/07", an, seg);
    end
    repeat (30) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_snapshot();
    test_blink();
    test_mode_restart();
    test_invalid();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
